// File: rtl/code_display_pkg.sv
// Shared types and segment constants for the code display path.
// Segment bit order is {a,b,c,d,e,f,g,dp}, 1 = lit.
package code_display_pkg;

    typedef enum logic [1:0] {
        MODE_HEX = 2'd0,
        MODE_BCD = 2'd1,
        MODE_DEC = 2'd2
    } mode_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_ERR   = 8'b1001_1110;

    // Element [0] is the rightmost entry of the concatenation.
    localparam logic [15:0][7:0] SEG_GLYPH = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    function automatic logic [7:0] glyph(input logic [3:0] v);
        return SEG_GLYPH[v];
    endfunction

endpackage

// File: rtl/code_display_scheduler_debouncer.sv
// Counter-based debouncer: a level is accepted after DEBOUNCE_CYCLES equal samples.
// A rising acceptance emits a one-cycle press pulse.
module button_debouncer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    logic [15:0] r_cnt;
    logic        r_level;
    logic        r_press;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                r_level <= raw;
                r_cnt   <= '0;
                r_press <= raw;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/code_display_scheduler.sv
// Mode-selectable 7-segment controller: debounced mode buttons, digit decode and
// two-digit time-multiplexed scan. Option: BLANK_LEADING_ZERO_EN blanks a DEC tens '0'.
module code_display_scheduler
    import code_display_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] SCAN_CYCLES     = 16'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] switches,
    input  logic [2:0] buttons,
    output logic [7:0] seg_out,
    output logic [1:0] dig_en,
    output logic [1:0] mode
);
    logic [2:0]  w_level;
    logic [2:0]  w_press;
    logic [2:0]  w_evt;
    logic [3:0]  r_sw_q;
    mode_t       r_mode;
    logic [15:0] r_scan_cnt;
    logic        r_digit_sel;
    logic [7:0]  r_seg;
    logic [1:0]  r_dig_en;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (buttons[i]),
            .level (w_level[i]),
            .press (w_press[i])
        );
    end

    // A pulse is only honoured together with the newly accepted high level.
    assign w_evt = w_press & w_level;

    logic       w_ge10;
    logic [3:0] w_dec_ones;
    logic [7:0] w_ones;
    logic [7:0] w_tens;
    logic       w_tens_on;
    logic [7:0] w_seg_nxt;
    logic [1:0] w_en_nxt;

    assign w_ge10     = (r_sw_q >= 4'd10);
    assign w_dec_ones = w_ge10 ? (r_sw_q - 4'd10) : r_sw_q;

    always_comb begin
        w_ones    = glyph(r_sw_q);
        w_tens    = SEG_BLANK;
        w_tens_on = 1'b1;
        case (r_mode)
            MODE_BCD: begin
                if (w_ge10) w_ones = SEG_ERR;
            end
            MODE_DEC: begin
                w_ones = glyph(w_dec_ones);
                w_tens = w_ge10 ? glyph(4'd1) : glyph(4'd0);
`ifdef BLANK_LEADING_ZERO_EN
                if (!w_ge10) begin
                    w_tens    = SEG_BLANK;
                    w_tens_on = 1'b0;
                end
`endif
            end
            default: ;
        endcase
    end

    // Count 0 is the anti-ghost blank cycle at the start of every slot.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        w_en_nxt  = 2'b00;
        if (r_scan_cnt != 16'd0) begin
            if (!r_digit_sel) begin
                w_seg_nxt = w_ones;
                w_en_nxt  = 2'b01;
            end else begin
                w_seg_nxt = w_tens;
                w_en_nxt  = {w_tens_on, 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_q      <= '0;
            r_mode      <= MODE_HEX;
            r_scan_cnt  <= '0;
            r_digit_sel <= 1'b0;
            r_seg       <= '0;
            r_dig_en    <= '0;
        end else begin
            r_sw_q <= switches;
            if (w_evt[0])      r_mode <= MODE_HEX;
            else if (w_evt[1]) r_mode <= MODE_BCD;
            else if (w_evt[2]) r_mode <= MODE_DEC;
            if (r_scan_cnt == SCAN_CYCLES - 16'd1) begin
                r_scan_cnt  <= '0;
                r_digit_sel <= ~r_digit_sel;
            end else begin
                r_scan_cnt <= r_scan_cnt + 16'd1;
            end
            r_seg    <= w_seg_nxt;
            r_dig_en <= w_en_nxt;
        end
    end

    assign seg_out = r_seg;
    assign dig_en  = r_dig_en;
    assign mode    = r_mode;

endmodule

// File: tb/tb_code_display_scheduler.sv
// Scoreboard bench for code_display_scheduler with short debounce/scan periods.
module tb_code_display_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] switches;
    logic [2:0] buttons;
    logic [7:0] seg_out;
    logic [1:0] dig_en;
    logic [1:0] mode;

    always #5 clk = ~clk;

    code_display_scheduler #(.DEBOUNCE_CYCLES(16'd4), .SCAN_CYCLES(16'd8)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .switches (switches),
        .buttons  (buttons),
        .seg_out  (seg_out),
        .dig_en   (dig_en),
        .mode     (mode)
    );

    typedef struct {
        logic [7:0] seg;
        logic [1:0] en;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Edges since reset release; output after edge c sits at scan phase (c-1)%16.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic int phase_of(input int c);
        return (c - 1) % 16;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int ph);
        int k = 0;
        while (phase_of(cyc) != ph && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) chk("wait_phase_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_seg"}, {24'd0, seg_out}, {24'd0, e.seg});
        chk({tag, "_en"},  {30'd0, dig_en},  {30'd0, e.en});
    endtask

    task automatic expect_slots(input string tag, input logic [7:0] ones,
                                input logic [7:0] tens, input logic [1:0] tens_en);
        sb_q.push_back(exp_t'{ones, 2'b01});
        sb_q.push_back(exp_t'{tens, tens_en});
        tick(3);
        wait_phase(4);
        pop_check({tag, "_ones"});
        wait_phase(12);
        pop_check({tag, "_tens"});
    endtask

    task automatic press(input logic [2:0] b);
        buttons = b;
        tick(5);
        buttons = 3'b000;
        tick(5);
    endtask

    initial begin
        logic [7:0] t6_tens;
        logic [1:0] t6_en;
        reset    = 1'b1;
        switches = 4'hB;
        buttons  = 3'b000;
        tick(3);
        chk("rst_seg",  {24'd0, seg_out}, 32'd0);
        chk("rst_en",   {30'd0, dig_en},  32'd0);
        chk("rst_mode", {30'd0, mode},    32'd0);
        reset = 1'b0;

        // 1: HEX 'b' on ones, blank tens with enable
        expect_slots("t1", 8'h3E, 8'h00, 2'b10);

        // 2: glitch rejected, held press selects DEC
        buttons = 3'b100;
        tick(2);
        buttons = 3'b000;
        tick(3);
        chk("t2_glitch_mode", {30'd0, mode}, 32'd0);
        press(3'b100);
        chk("t2_mode", {30'd0, mode}, 32'd2);
        switches = 4'hD;
        expect_slots("t2", 8'hF2, 8'h60, 2'b10);

        // 3: BCD error glyph, then mid-slot switch change
        switches = 4'hC;
        press(3'b010);
        chk("t3_mode", {30'd0, mode}, 32'd1);
        expect_slots("t3", 8'h9E, 8'h00, 2'b10);
        tick(1);
        wait_phase(2);
        switches = 4'h7;
        sb_q.push_back(exp_t'{8'hE0, 2'b01});
        tick(2);
        pop_check("t3_mid");

        // 4: simultaneous presses, lowest index wins
        press(3'b111);
        chk("t4_mode", {30'd0, mode}, 32'd0);

        // 5: scan sequence over 32 cycles in HEX with 'b'
        switches = 4'hB;
        tick(3);
        for (int i = 0; i < 32; i++) begin
            int ph;
            exp_t e;
            @(negedge clk);
            ph = phase_of(cyc);
            if (ph >= 1 && ph <= 7) e = exp_t'{8'h3E, 2'b01};
            else if (ph >= 9)       e = exp_t'{8'h00, 2'b10};
            else                    e = exp_t'{8'h00, 2'b00};
            sb_q.push_back(e);
            pop_check("t5");
            chk("t5_no_11", {31'd0, dig_en == 2'b11}, 32'd0);
            if (dig_en == 2'b00) chk("t5_blank_seg", {24'd0, seg_out}, 32'd0);
        end

        // 6: DEC leading zero, then reset mid tens slot
        switches = 4'h3;
        press(3'b100);
        chk("t6_mode", {30'd0, mode}, 32'd2);
`ifdef BLANK_LEADING_ZERO_EN
        t6_tens = 8'h00;
        t6_en   = 2'b00;
`else
        t6_tens = 8'hFC;
        t6_en   = 2'b10;
`endif
        expect_slots("t6", 8'hF2, t6_tens, t6_en);
        wait_phase(11);
        reset = 1'b1;
        tick(1);
        chk("t6_rst_seg",  {24'd0, seg_out}, 32'd0);
        chk("t6_rst_en",   {30'd0, dig_en},  32'd0);
        chk("t6_rst_mode", {30'd0, mode},    32'd0);
        reset = 1'b0;
        tick(1);
        chk("t6_post_blank_en", {30'd0, dig_en}, 32'd0);
        tick(1);
        chk("t6_post_ones_en", {30'd0, dig_en}, 32'd1);
        expect_slots("t6_post", 8'hF2, 8'h00, 2'b10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
